// File: rtl/rvfi_commit_packer.sv
// Retirement-monitor producer: compacts sparse ROB commit slots onto the
// low monitor lanes, numbers them, normalises don't-care fields, stops after
// the first halt and watches the PC chain across emitted instructions.
module rvfi_commit_packer #(
    parameter int COMMIT_W = 4,
    parameter int LANES    = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [COMMIT_W-1:0]              c_valid,
    input  logic [COMMIT_W-1:0][31:0]        c_inst,
    input  logic [COMMIT_W-1:0][4:0]         c_rs1_addr,
    input  logic [COMMIT_W-1:0][4:0]         c_rs2_addr,
    input  logic [COMMIT_W-1:0][31:0]        c_rs1_rdata,
    input  logic [COMMIT_W-1:0][31:0]        c_rs2_rdata,
    input  logic [COMMIT_W-1:0][4:0]         c_rd_addr,
    input  logic [COMMIT_W-1:0][31:0]        c_rd_wdata,
    input  logic [COMMIT_W-1:0][31:0]        c_pc_rdata,
    input  logic [COMMIT_W-1:0][31:0]        c_pc_wdata,
    input  logic [COMMIT_W-1:0][31:0]        c_mem_addr,
    input  logic [COMMIT_W-1:0][3:0]         c_mem_rmask,
    input  logic [COMMIT_W-1:0][3:0]         c_mem_wmask,
    input  logic [COMMIT_W-1:0][31:0]        c_mem_rdata,
    input  logic [COMMIT_W-1:0][31:0]        c_mem_wdata,
    input  logic [COMMIT_W-1:0]              c_halt,
    output logic [LANES-1:0]                 m_valid,
    output logic [LANES-1:0][63:0]           m_order,
    output logic [LANES-1:0]                 m_halt,
    output logic [LANES-1:0][31:0]           m_inst,
    output logic [LANES-1:0][4:0]            m_rs1_addr,
    output logic [LANES-1:0][4:0]            m_rs2_addr,
    output logic [LANES-1:0][31:0]           m_rs1_rdata,
    output logic [LANES-1:0][31:0]           m_rs2_rdata,
    output logic [LANES-1:0][4:0]            m_rd_addr,
    output logic [LANES-1:0][31:0]           m_rd_wdata,
    output logic [LANES-1:0][31:0]           m_pc_rdata,
    output logic [LANES-1:0][31:0]           m_pc_wdata,
    output logic [LANES-1:0][31:0]           m_mem_addr,
    output logic [LANES-1:0][3:0]            m_mem_rmask,
    output logic [LANES-1:0][3:0]            m_mem_wmask,
    output logic [LANES-1:0][31:0]           m_mem_rdata,
    output logic [LANES-1:0][31:0]           m_mem_wdata,
    output logic                             halted,
    output logic                             pc_err,
    output logic [63:0]                      commit_cnt
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    typedef struct packed {
        logic        valid;
        logic        halt;
        logic [63:0] order;
        logic [31:0] inst;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] rs1_rdata;
        logic [31:0] rs2_rdata;
        logic [4:0]  rd_addr;
        logic [31:0] rd_wdata;
        logic [31:0] pc_rdata;
        logic [31:0] pc_wdata;
        logic [31:0] mem_addr;
        logic [3:0]  mem_rmask;
        logic [3:0]  mem_wmask;
        logic [31:0] mem_rdata;
        logic [31:0] mem_wdata;
    } lane_t;

    lane_t       lane_d [LANES];
    lane_t       lane_q [LANES];
    logic [63:0] cnt_d, cnt_q;
    logic        halted_d, halted_q;
    logic        pc_err_d, pc_err_q;
    logic        first_d, first_q;
    logic [31:0] last_pc_d, last_pc_q;
    logic        eff;
    logic        halt_seen;
    logic        mem_used;
    logic [LW-1:0] lane_idx;

    // Compaction, numbering, normalisation, halt cut-off and PC chain walk.
    // Slots are walked low to high so the lane index is the count of
    // effective slots already placed, and the chain check sees instructions
    // in the same order the monitor will.
    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            lane_d[j] = '0;
        end
        eff       = 1'b0;
        mem_used  = 1'b0;
        halt_seen = 1'b0;
        lane_idx  = '0;
        cnt_d     = cnt_q;
        last_pc_d = last_pc_q;
        first_d   = first_q;
        pc_err_d  = pc_err_q;
        for (int i = 0; i < COMMIT_W; i++) begin
            eff = c_valid[i] & ~halted_q & ~halt_seen;
            if (eff) begin
                mem_used = (c_mem_rmask[i] != 4'h0) || (c_mem_wmask[i] != 4'h0);
                lane_d[lane_idx].valid     = 1'b1;
                lane_d[lane_idx].halt      = c_halt[i];
                lane_d[lane_idx].order     = cnt_d;
                lane_d[lane_idx].inst      = c_inst[i];
                lane_d[lane_idx].rs1_addr  = c_rs1_addr[i];
                lane_d[lane_idx].rs2_addr  = c_rs2_addr[i];
                lane_d[lane_idx].rs1_rdata = c_rs1_rdata[i];
                lane_d[lane_idx].rs2_rdata = c_rs2_rdata[i];
                lane_d[lane_idx].rd_addr   = c_rd_addr[i];
                lane_d[lane_idx].rd_wdata  = (c_rd_addr[i] == 5'd0) ? 32'h0 : c_rd_wdata[i];
                lane_d[lane_idx].pc_rdata  = c_pc_rdata[i];
                lane_d[lane_idx].pc_wdata  = c_pc_wdata[i];
                lane_d[lane_idx].mem_addr  = mem_used ? c_mem_addr[i]  : 32'h0;
                lane_d[lane_idx].mem_rmask = c_mem_rmask[i];
                lane_d[lane_idx].mem_wmask = c_mem_wmask[i];
                lane_d[lane_idx].mem_rdata = mem_used ? c_mem_rdata[i] : 32'h0;
                lane_d[lane_idx].mem_wdata = mem_used ? c_mem_wdata[i] : 32'h0;
                if (!first_d && (c_pc_rdata[i] != last_pc_d)) begin
                    pc_err_d = 1'b1;
                end
                last_pc_d = c_pc_wdata[i];
                first_d   = 1'b0;
                if (c_halt[i]) begin
                    halt_seen = 1'b1;
                end
                lane_idx = lane_idx + 1'b1;
                cnt_d    = cnt_d + 64'd1;
            end
        end
        halted_d = halted_q | halt_seen;
    end

    // Lane and bookkeeping registers; reset drops whatever is on the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < LANES; j++) begin
                lane_q[j] <= '0;
            end
            cnt_q     <= 64'd0;
            halted_q  <= 1'b0;
            pc_err_q  <= 1'b0;
            first_q   <= 1'b1;
            last_pc_q <= 32'h0;
        end else begin
            for (int j = 0; j < LANES; j++) begin
                lane_q[j] <= lane_d[j];
            end
            cnt_q     <= cnt_d;
            halted_q  <= halted_d;
            pc_err_q  <= pc_err_d;
            first_q   <= first_d;
            last_pc_q <= last_pc_d;
        end
    end

    // Fan the registered lane records out onto the flat monitor ports.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        assign m_valid[j]     = lane_q[j].valid;
        assign m_halt[j]      = lane_q[j].halt;
        assign m_order[j]     = lane_q[j].order;
        assign m_inst[j]      = lane_q[j].inst;
        assign m_rs1_addr[j]  = lane_q[j].rs1_addr;
        assign m_rs2_addr[j]  = lane_q[j].rs2_addr;
        assign m_rs1_rdata[j] = lane_q[j].rs1_rdata;
        assign m_rs2_rdata[j] = lane_q[j].rs2_rdata;
        assign m_rd_addr[j]   = lane_q[j].rd_addr;
        assign m_rd_wdata[j]  = lane_q[j].rd_wdata;
        assign m_pc_rdata[j]  = lane_q[j].pc_rdata;
        assign m_pc_wdata[j]  = lane_q[j].pc_wdata;
        assign m_mem_addr[j]  = lane_q[j].mem_addr;
        assign m_mem_rmask[j] = lane_q[j].mem_rmask;
        assign m_mem_wmask[j] = lane_q[j].mem_wmask;
        assign m_mem_rdata[j] = lane_q[j].mem_rdata;
        assign m_mem_wdata[j] = lane_q[j].mem_wdata;
    end

    assign halted     = halted_q;
    assign pc_err     = pc_err_q;
    assign commit_cnt = cnt_q;

endmodule

// File: tb/tb_rvfi_commit_packer.sv
// Directed bench for rvfi_commit_packer: a vector table for the cycle-level
// behaviour plus a hand-written normalisation sequence.
module tb_rvfi_commit_packer;

    localparam int CW = 4;
    localparam int LN = 8;

    logic                   clk;
    logic                   rst;
    logic [CW-1:0]          c_valid;
    logic [CW-1:0][31:0]    c_inst, c_rs1_rdata, c_rs2_rdata, c_rd_wdata;
    logic [CW-1:0][31:0]    c_pc_rdata, c_pc_wdata, c_mem_addr, c_mem_rdata, c_mem_wdata;
    logic [CW-1:0][4:0]     c_rs1_addr, c_rs2_addr, c_rd_addr;
    logic [CW-1:0][3:0]     c_mem_rmask, c_mem_wmask;
    logic [CW-1:0]          c_halt;
    logic [LN-1:0]          m_valid, m_halt;
    logic [LN-1:0][63:0]    m_order;
    logic [LN-1:0][31:0]    m_inst, m_rs1_rdata, m_rs2_rdata, m_rd_wdata;
    logic [LN-1:0][31:0]    m_pc_rdata, m_pc_wdata, m_mem_addr, m_mem_rdata, m_mem_wdata;
    logic [LN-1:0][4:0]     m_rs1_addr, m_rs2_addr, m_rd_addr;
    logic [LN-1:0][3:0]     m_mem_rmask, m_mem_wmask;
    logic                   halted, pc_err;
    logic [63:0]            commit_cnt;

    int checks = 0;
    int errors = 0;

    rvfi_commit_packer #(.COMMIT_W(CW), .LANES(LN)) dut (
        .clk(clk), .rst(rst), .c_valid(c_valid), .c_inst(c_inst),
        .c_rs1_addr(c_rs1_addr), .c_rs2_addr(c_rs2_addr),
        .c_rs1_rdata(c_rs1_rdata), .c_rs2_rdata(c_rs2_rdata),
        .c_rd_addr(c_rd_addr), .c_rd_wdata(c_rd_wdata),
        .c_pc_rdata(c_pc_rdata), .c_pc_wdata(c_pc_wdata),
        .c_mem_addr(c_mem_addr), .c_mem_rmask(c_mem_rmask), .c_mem_wmask(c_mem_wmask),
        .c_mem_rdata(c_mem_rdata), .c_mem_wdata(c_mem_wdata), .c_halt(c_halt),
        .m_valid(m_valid), .m_order(m_order), .m_halt(m_halt), .m_inst(m_inst),
        .m_rs1_addr(m_rs1_addr), .m_rs2_addr(m_rs2_addr),
        .m_rs1_rdata(m_rs1_rdata), .m_rs2_rdata(m_rs2_rdata),
        .m_rd_addr(m_rd_addr), .m_rd_wdata(m_rd_wdata),
        .m_pc_rdata(m_pc_rdata), .m_pc_wdata(m_pc_wdata),
        .m_mem_addr(m_mem_addr), .m_mem_rmask(m_mem_rmask), .m_mem_wmask(m_mem_wmask),
        .m_mem_rdata(m_mem_rdata), .m_mem_wdata(m_mem_wdata),
        .halted(halted), .pc_err(pc_err), .commit_cnt(commit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  halt;
        logic [31:0] start;
        int          brk;
        logic [7:0]  e_valid;
        logic [7:0]  e_halt;
        logic [63:0] e_ord0;
        logic [63:0] e_cnt;
        logic        e_halted;
        logic        e_pcerr;
        int          src0;
        int          src1;
    } vec_t;

    vec_t vecs [17];

    function automatic logic [31:0] inst_of(int n, int i);
        return 32'hA000_0000 + 32'(n * 256 + i);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Fill every slot; PCs form an unbroken chain over the valid slots
    // starting at 'start', except slot 'brk' whose pc_rdata is 0x2000.
    task automatic set_slots(input int n, input logic [3:0] v, input logic [3:0] h,
                             input logic [31:0] start, input int brk);
        int below;
        below = 0;
        c_valid = v;
        c_halt  = h;
        for (int i = 0; i < CW; i++) begin
            c_inst[i]      = inst_of(n, i);
            c_rs1_addr[i]  = 5'(i + 1);
            c_rs2_addr[i]  = 5'(i + 2);
            c_rd_addr[i]   = 5'(i + 1);
            c_rs1_rdata[i] = 32'h1100_0000 + 32'(n * 256 + i);
            c_rs2_rdata[i] = 32'h2200_0000 + 32'(n * 256 + i);
            c_rd_wdata[i]  = 32'h3300_0000 + 32'(n * 256 + i);
            c_mem_addr[i]  = 32'h8000_0000 + 32'(n * 256 + i);
            c_mem_rdata[i] = 32'h4400_0000 + 32'(n * 256 + i);
            c_mem_wdata[i] = 32'h5500_0000 + 32'(n * 256 + i);
            c_mem_rmask[i] = 4'hF;
            c_mem_wmask[i] = 4'h3;
            if (v[i]) begin
                c_pc_rdata[i] = start + 32'(4 * below);
                c_pc_wdata[i] = start + 32'(4 * below + 4);
                below++;
            end else begin
                c_pc_rdata[i] = 32'hBAD0_0000 + 32'(i);
                c_pc_wdata[i] = 32'hBAD1_0000 + 32'(i);
            end
            if (brk == i) c_pc_rdata[i] = 32'h2000;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic idle_ok;
        int   k;

        //            rst   valid  halt   start         brk  e_valid e_halt e_ord0 e_cnt  hlt   perr  s0  s1
        vecs[0]  = '{1'b1, 4'hF, 4'h0, 32'h0000_0000, -1, 8'h00, 8'h00, 64'd0,  64'd0,  1'b0, 1'b0, -1, -1};
        vecs[1]  = '{1'b0, 4'hF, 4'h0, 32'h0000_1000, -1, 8'h0F, 8'h00, 64'd0,  64'd4,  1'b0, 1'b0,  0,  1};
        vecs[2]  = '{1'b0, 4'hA, 4'h0, 32'h0000_1010, -1, 8'h03, 8'h00, 64'd4,  64'd6,  1'b0, 1'b0,  1,  3};
        vecs[3]  = '{1'b0, 4'h0, 4'h0, 32'h0000_0000, -1, 8'h00, 8'h00, 64'd0,  64'd6,  1'b0, 1'b0, -1, -1};
        vecs[4]  = '{1'b0, 4'h5, 4'h0, 32'h0000_1018, -1, 8'h03, 8'h00, 64'd6,  64'd8,  1'b0, 1'b0,  0,  2};
        vecs[5]  = '{1'b0, 4'h3, 4'h0, 32'h0000_1020,  1, 8'h03, 8'h00, 64'd8,  64'd10, 1'b0, 1'b1,  0,  1};
        vecs[6]  = '{1'b0, 4'hF, 4'h0, 32'h0000_1028, -1, 8'h0F, 8'h00, 64'd10, 64'd14, 1'b0, 1'b1,  0,  1};
        vecs[7]  = '{1'b1, 4'hF, 4'h0, 32'h0000_1038, -1, 8'h00, 8'h00, 64'd0,  64'd0,  1'b0, 1'b0, -1, -1};
        vecs[8]  = '{1'b0, 4'h6, 4'h0, 32'h0000_5000, -1, 8'h03, 8'h00, 64'd0,  64'd2,  1'b0, 1'b0,  1,  2};
        vecs[9]  = '{1'b0, 4'hF, 4'h2, 32'h0000_5008, -1, 8'h03, 8'h02, 64'd2,  64'd4,  1'b1, 1'b0,  0,  1};
        vecs[10] = '{1'b0, 4'hF, 4'h0, 32'h0000_5010, -1, 8'h00, 8'h00, 64'd0,  64'd4,  1'b1, 1'b0, -1, -1};
        vecs[11] = '{1'b1, 4'hF, 4'h0, 32'h0000_0000, -1, 8'h00, 8'h00, 64'd0,  64'd0,  1'b0, 1'b0, -1, -1};
        vecs[12] = '{1'b0, 4'h8, 4'h8, 32'h0000_7000, -1, 8'h01, 8'h01, 64'd0,  64'd1,  1'b1, 1'b0,  3, -1};
        vecs[13] = '{1'b1, 4'h0, 4'h0, 32'h0000_0000, -1, 8'h00, 8'h00, 64'd0,  64'd0,  1'b0, 1'b0, -1, -1};
        vecs[14] = '{1'b0, 4'hF, 4'h1, 32'h0000_7100, -1, 8'h01, 8'h01, 64'd0,  64'd1,  1'b1, 1'b0,  0, -1};
        vecs[15] = '{1'b1, 4'h0, 4'h0, 32'h0000_0000, -1, 8'h00, 8'h00, 64'd0,  64'd0,  1'b0, 1'b0, -1, -1};
        vecs[16] = '{1'b0, 4'hE, 4'hC, 32'h0000_7200, -1, 8'h03, 8'h02, 64'd0,  64'd2,  1'b1, 1'b0,  1,  2};

        rst = 1'b1;
        set_slots(0, 4'h0, 4'h0, 32'h0, -1);
        tick();
        tick();

        foreach (vecs[n]) begin
            rst = vecs[n].rst;
            set_slots(n, vecs[n].valid, vecs[n].halt, vecs[n].start, vecs[n].brk);
            tick();
            chk($sformatf("v%0d m_valid", n), 64'(m_valid), 64'(vecs[n].e_valid));
            chk($sformatf("v%0d m_halt", n), 64'(m_halt), 64'(vecs[n].e_halt));
            chk($sformatf("v%0d commit_cnt", n), commit_cnt, vecs[n].e_cnt);
            chk($sformatf("v%0d halted", n), 64'(halted), 64'(vecs[n].e_halted));
            chk($sformatf("v%0d pc_err", n), 64'(pc_err), 64'(vecs[n].e_pcerr));
            if (vecs[n].e_valid[0]) chk($sformatf("v%0d order0", n), m_order[0], vecs[n].e_ord0);
            if (vecs[n].e_valid[1]) chk($sformatf("v%0d order1", n), m_order[1], vecs[n].e_ord0 + 64'd1);
            chk($sformatf("v%0d inst0", n), 64'(m_inst[0]),
                (vecs[n].src0 < 0) ? 64'd0 : 64'(inst_of(n, vecs[n].src0)));
            chk($sformatf("v%0d inst1", n), 64'(m_inst[1]),
                (vecs[n].src1 < 0) ? 64'd0 : 64'(inst_of(n, vecs[n].src1)));
            k = $countones(vecs[n].e_valid);
            idle_ok = 1'b1;
            for (int j = 0; j < LN; j++) begin
                if (j >= k && (m_inst[j] != 32'h0 || m_pc_wdata[j] != 32'h0 ||
                               m_rs1_rdata[j] != 32'h0 || m_mem_addr[j] != 32'h0)) begin
                    idle_ok = 1'b0;
                end
            end
            chk($sformatf("v%0d idle_lanes_zero", n), 64'(idle_ok), 64'd1);
        end

        // Normalisation: rd x0 write data and unused memory fields are zeroed.
        rst = 1'b1;
        set_slots(0, 4'h0, 4'h0, 32'h0, -1);
        tick();
        rst = 1'b0;
        set_slots(99, 4'h3, 4'h0, 32'h9000, -1);
        c_rd_addr[0]   = 5'd0;
        c_rd_wdata[0]  = 32'hDEAD_BEEF;
        c_mem_wmask[0] = 4'h0;
        c_mem_rmask[1] = 4'h0;
        c_mem_wmask[1] = 4'h0;
        c_mem_addr[1]  = 32'h40;
        tick();
        chk("norm m_valid", 64'(m_valid), 64'h03);
        chk("norm rd_wdata0", 64'(m_rd_wdata[0]), 64'd0);
        chk("norm rd_wdata1", 64'(m_rd_wdata[1]), 64'h3300_6301);
        chk("norm mem_addr0", 64'(m_mem_addr[0]), 64'h8000_6300);
        chk("norm mem_rdata0", 64'(m_mem_rdata[0]), 64'h4400_6300);
        chk("norm mem_wmask0", 64'(m_mem_wmask[0]), 64'h0);
        chk("norm mem_addr1", 64'(m_mem_addr[1]), 64'd0);
        chk("norm mem_rdata1", 64'(m_mem_rdata[1]), 64'd0);
        chk("norm mem_wdata1", 64'(m_mem_wdata[1]), 64'd0);
        chk("norm rs2_rdata1", 64'(m_rs2_rdata[1]), 64'h2200_6301);
        chk("norm rs1_addr1", 64'(m_rs1_addr[1]), 64'd2);
        chk("norm rs2_addr0", 64'(m_rs2_addr[0]), 64'd2);
        chk("norm rd_addr0", 64'(m_rd_addr[0]), 64'd0);
        chk("norm pc_rdata1", 64'(m_pc_rdata[1]), 64'h9004);
        chk("norm pc_wdata1", 64'(m_pc_wdata[1]), 64'h9008);
        chk("norm pc_err", 64'(pc_err), 64'd0);

        // Lanes hold for one cycle only.
        c_valid = 4'h0;
        tick();
        chk("hold m_valid", 64'(m_valid), 64'h00);
        chk("hold commit_cnt", commit_cnt, 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvfi_commit_packer.md
Name: rvfi_commit_packer

Overview:
- Producer side of the 8-lane retirement monitor bundle. Sits at the ROB commit port and drives the monitor lanes.
- Accepts up to COMMIT_W possibly sparse commit slots per cycle. Compacts valid slots into contiguous low lanes, assigns monotonically increasing order numbers, normalises fields, and registers everything onto the lanes.
- Enforces the stop-after-halt rule and flags PC-chain breaks.

Parameters:
- COMMIT_W, 4, number of ROB commit slots per cycle; must satisfy 1 <= COMMIT_W <= LANES.
- LANES, 8, monitor lanes driven.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- c_valid  in  COMMIT_W  per-slot commit valid; may be sparse.
- c_inst, c_rs1_rdata, c_rs2_rdata, c_rd_wdata, c_pc_rdata, c_pc_wdata, c_mem_addr, c_mem_rdata, c_mem_wdata  in  COMMIT_W x 32  per-slot fields.
- c_rs1_addr, c_rs2_addr, c_rd_addr  in  COMMIT_W x 5  per-slot register addresses.
- c_mem_rmask, c_mem_wmask  in  COMMIT_W x 4  per-slot byte masks.
- c_halt  in  COMMIT_W  per-slot halt marker.
- m_valid  out  LANES  monitor lane valid.
- m_order  out  LANES x 64  retirement order.
- m_halt  out  LANES  lane halt flag.
- m_<field>  out  LANES x (field width)  one per c_ field above, same widths.
- halted  out  1  sticky; a halt has been emitted.
- pc_err  out  1  sticky; PC chain break detected.
- commit_cnt  out  64  total instructions emitted; equals next order.

Behaviour:
- Reset:
  - All m_valid = 0 and every m_ field = 0.
  - m_order = 0, halted = 0, pc_err = 0, commit_cnt = 0.
  - Chain-check "first" flag = 1.
  - Reset mid-stream discards the cycle's inputs; the next emitted order is 0.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on m_* after edge N and hold for one cycle. No backpressure; the monitor always accepts.
- Compaction:
  - Let k = popcount(effective valid).
  - Effective slot i is placed on lane j = number of effective valid slots below i.
  - Lanes 0..k-1 get m_valid = 1; lanes k..LANES-1 get m_valid = 0 with all their fields forced to 0.
  - Slot order is preserved.
- Order:
  - Lane j gets m_order = commit_cnt + j.
  - commit_cnt += k each cycle, 64-bit, wraps modulo 2^64 with no flag.
- Normalisation:
  - If c_rd_addr = 0, m_rd_wdata = 0 regardless of input.
  - If both masks are 0, m_mem_addr, m_mem_rdata and m_mem_wdata = 0.
  - All other fields pass through unchanged.
- Halt:
  - The lowest valid slot with c_halt = 1 is emitted with m_halt = 1.
  - Valid slots above it in the same cycle are dropped: not emitted, not counted.
  - halted is set on the same edge the halt lane is registered.
  - While halted = 1, every effective valid = 0. Only rst clears halted.
- PC chain check:
  - A register last_pc_wdata holds c_pc_wdata of the last emitted instruction.
  - For each emitted instruction in lane order, expected pc_rdata = previous emitted pc_wdata. Within a cycle, "previous" is the lower lane; for lane 0 it is last_pc_wdata.
  - The check is skipped when the "first" flag is set (first instruction after reset); "first" clears after the first emission.
  - Any mismatch sets pc_err (sticky) one edge later, aligned with the lane output. Only rst clears pc_err.
  - Emission continues normally after a mismatch.
- Cycle with k = 0: all m_valid = 0, counters unchanged.

Test Plan:
- Reset, then c_valid = 4'b1111 with pc chain 0x1000->0x1004->0x1008->0x100C->0x1010 -> next cycle m_valid = 8'h0F, m_order = 0..3, commit_cnt = 4, pc_err = 0.
- c_valid = 4'b1010 with the 2-cycle prior state (commit_cnt = 4) -> slot1 lands on lane0 with order 4, slot3 on lane1 with order 5, lanes 2..7 valid 0 and fields 0, commit_cnt = 6.
- Slot0 has c_rd_addr = 0 and c_rd_wdata = 0xDEADBEEF; slot1 has both masks 0 and c_mem_addr = 0x40 -> m_rd_wdata[0] = 0, m_mem_addr[1] = 0.
- c_valid = 4'b1111 with c_halt = 4'b0010 -> lanes 0,1 valid, m_halt[1] = 1, order advances by 2, halted = 1. A further c_valid = 4'b1111 next cycle -> m_valid = 0, commit_cnt unchanged.
- Lane1 has pc_rdata = 0x2000 while lane0 has pc_wdata = 0x1004 -> pc_err = 1 with that output cycle and stays 1. A following correct chain keeps pc_err = 1.
- rst asserted with valid inputs mid-stream -> m_valid = 0 next cycle. The next commit after release emits order 0 with no pc check, and pc_err = 0.
